// File: rtl/serial_sub16.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to register signed overflow on ovf; otherwise ovf is tied to 0.
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic             br_q, br_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] dOut_q, dOut_d;
  logic             bout_q, bout_d;
  logic             ai, bi, di, brNext, lastBit;

  assign ai      = aSh_q[0];
  assign bi      = bSh_q[0];
  assign di      = ai ^ bi ^ br_q;
  assign brNext  = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign lastBit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // The working shift register is separate from dOut_q so the visible result holds during RUN.
  always_comb begin
    aSh_d  = aSh_q;
    bSh_d  = bSh_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    dOut_d = dOut_q;
    bout_d = bout_q;
    if (state_q == IDLE && start) begin
      aSh_d = a;
      bSh_d = b;
      br_d  = bin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      aSh_d = aSh_q >> 1;
      bSh_d = bSh_q >> 1;
      br_d  = brNext;
      cnt_d = cnt_q + CW'(1);
      res_d = (WIDTH-1)'({di, res_q} >> 1);
      if (lastBit) begin
        dOut_d = {di, res_q};
        bout_d = brNext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aSh_q  <= '0;
      bSh_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      dOut_q <= '0;
      bout_q <= 1'b0;
    end else begin
      aSh_q  <= aSh_d;
      bSh_q  <= bSh_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      dOut_q <= dOut_d;
      bout_q <= bout_d;
    end
  end

  assign d    = dOut_q;
  assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;

  // On the last bit the shifters hold the operand MSBs and di is the result MSB.
  always_comb begin
    ovf_d = ovf_q;
    if (lastBit) ovf_d = (ai != bi) && (di != ai);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16: a cycle-count model queues expected results,
// a negedge monitor compares handshake and outputs every cycle.
module tb_serial_sub16;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] d;
  logic         bout, ovf;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   modelLeft = 0;

  logic [W-1:0] heldD;
  logic         heldBout, heldOvf;

  serial_sub16 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  function automatic exp_t refModel(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t e;
    longint unsigned ua, ub;
    ua = longint'(ma);
    ub = longint'(mb) + longint'(mbin);
    e.d = W'(ua - ub);
    e.bout = (ua < ub);
`ifdef SERIAL_SUB_OVF_EN
    e.ovf = (ma[W-1] != mb[W-1]) && (e.d[W-1] != ma[W-1]);
`else
    e.ovf = 1'b0;
`endif
    e.acc = 0;
    return e;
  endfunction

  // Timing model: an accepted request keeps the block unavailable for W RUN cycles plus one DONE cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelLeft = 0;
      expQ.delete();
    end else begin
      exp_t e;
      cycle++;
      if (modelLeft > 0) modelLeft--;
      else if (start) begin
        e = refModel(a, b, bin);
        e.acc = cycle;
        expQ.push_back(e);
        modelLeft = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      heldD = '0;
      heldBout = 1'b0;
      heldOvf = 1'b0;
    end
    checkOutput("busy", 32'(busy), 32'(modelLeft >= 2));
    checkOutput("done", 32'(done), 32'(modelLeft == 1));
    if (done) begin
      if (expQ.size() == 0) begin
        checkOutput("doneUnexpected", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("d", 32'(d), 32'(e.d));
        checkOutput("bout", 32'(bout), 32'(e.bout));
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
        checkOutput("latency", 32'(cycle - e.acc), 32'(W));
        heldD = e.d;
        heldBout = e.bout;
        heldOvf = e.ovf;
      end
    end else begin
      checkOutput("dHold", 32'(d), 32'(heldD));
      checkOutput("boutHold", 32'(bout), 32'(heldBout));
      checkOutput("ovfHold", 32'(ovf), 32'(heldOvf));
    end
  end

  task automatic applyStimulus(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sbin);
    @(negedge clk);
    #1;
    start = 1'b1;
    a = sa;
    b = sb;
    bin = sbin;
    @(negedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (modelLeft != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idleTimeout", 32'(n >= 200), 32'(0));
    @(negedge clk);
  endtask

  logic [W-1:0] vecA [6] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h8000};
  logic [W-1:0] vecB [6] = '{16'h0000, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001};
  logic         vecC [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] reset in the middle of a run");
    applyStimulus(16'hA5A5, 16'h1234, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(16'd5, 16'd3, 1'b0);
    waitIdle();

    $display("[TB] directed corner cases");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecA[i], vecB[i], vecC[i]);
      waitIdle();
    end

    $display("[TB] start while busy is ignored");
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(16'h1234, 16'h0000, 1'b0);
    waitIdle();

    $display("[TB] start held high with changing inputs");
    @(negedge clk);
    #1;
    start = 1'b1;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    waitIdle();

    $display("[TB] random operations");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) waitIdle();
      else repeat ($urandom_range(0, W + 2)) @(negedge clk);
    end
    waitIdle();

    repeat (3) @(negedge clk);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
